// File: rtl/traffic_light_safety_monitor.sv
// traffic_light_safety_monitor
// Registered pass-through of the four controller light outputs to the lamp
// drivers. The block checks light encoding, mutual exclusion, phase order and
// minimum phase durations. On the first violation it latches a fault code and
// drives flashing red until an operator clear is accepted.
//
// Clear handshake: clear_fault is a level, sampled on every rising edge. It
// is accepted only in FAULT_FLASH and only on an edge where all four inputs
// are RED. On that edge the monitor returns to MONITOR and the fault code is
// dropped. At any other time clear_fault is ignored.
//
// The FSM state is visible on the fault output: fault is 1 exactly when the
// state register holds FAULT_FLASH.
module traffic_light_safety_monitor #(
    parameter int unsigned MIN_GREEN  = 4,
    parameter int unsigned MIN_YELLOW = 2,
    parameter int unsigned MIN_ALLRED = 1,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] North,
    input  logic [2:0] East,
    input  logic [2:0] South,
    input  logic [2:0] West,
    input  logic       clear_fault,
    output logic [2:0] North_out,
    output logic [2:0] East_out,
    output logic [2:0] South_out,
    output logic [2:0] West_out,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] violation_count
);

    // Light encodings shared by the controller and the lamp drivers.
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    // Thresholds narrowed to the 8-bit counter width used throughout.
    localparam logic [7:0] MIN_GREEN_C  = 8'(MIN_GREEN);
    localparam logic [7:0] MIN_YELLOW_C = 8'(MIN_YELLOW);
    localparam logic [7:0] MIN_ALLRED_C = 8'(MIN_ALLRED);
    localparam logic [7:0] FLASH_LAST_C = 8'(FLASH_HALF) - 8'd1;
    localparam logic [7:0] SAT_MAX      = 8'hFF;

    // Fault codes; lower value means higher priority.
    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ENCODING = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_SEQUENCE = 3'd3;
    localparam logic [2:0] CODE_GREEN    = 3'd4;
    localparam logic [2:0] CODE_YELLOW   = 3'd5;
    localparam logic [2:0] CODE_ALLRED   = 3'd6;

    typedef enum logic {
        S_MONITOR = 1'b0,
        S_FAULT   = 1'b1
    } state_e;

    // Direction index: 0 = North, 1 = East, 2 = South, 3 = West.
    logic [3:0][2:0] lights_in;

    state_e          state_q,     state_d;
    logic [3:0][2:0] prev_q,      prev_d;
    logic [3:0][7:0] run_q,       run_d;
    logic [7:0]      allred_q,    allred_d;
    logic [7:0]      flash_cnt_q, flash_cnt_d;
    logic            flash_dark_q, flash_dark_d;
    logic [3:0][2:0] out_q,       out_d;
    logic [2:0]      code_q,      code_d;
    logic [7:0]      vcount_q,    vcount_d;

    logic       all_red;
    logic [2:0] nonred_cnt;
    logic       v_encoding;
    logic       v_conflict;
    logic       v_sequence;
    logic       v_green;
    logic       v_yellow;
    logic       v_allred;
    logic [2:0] viol_code;

    assign lights_in = {West, South, East, North};
    assign all_red   = (North == RED) && (East == RED) &&
                       (South == RED) && (West == RED);

    // Evaluate every rule on the sampled inputs against the tracked history and
    // reduce the hits to the single highest-priority (lowest) code.
    always_comb begin
        v_encoding = 1'b0;
        v_sequence = 1'b0;
        v_green    = 1'b0;
        v_yellow   = 1'b0;
        v_allred   = 1'b0;
        nonred_cnt = 3'd0;
        for (int d = 0; d < 4; d++) begin
            if (!((lights_in[d] == RED) || (lights_in[d] == YELLOW) ||
                  (lights_in[d] == GREEN))) begin
                v_encoding = 1'b1;
            end
            if (lights_in[d] != RED) begin
                nonred_cnt = nonred_cnt + 3'd1;
            end
            if (((prev_q[d] == GREEN)  && (lights_in[d] == RED))    ||
                ((prev_q[d] == RED)    && (lights_in[d] == YELLOW)) ||
                ((prev_q[d] == YELLOW) && (lights_in[d] == GREEN))) begin
                v_sequence = 1'b1;
            end
            if ((prev_q[d] == GREEN) && (lights_in[d] == YELLOW) &&
                (run_q[d] < MIN_GREEN_C)) begin
                v_green = 1'b1;
            end
            if ((prev_q[d] == YELLOW) && (lights_in[d] == RED) &&
                (run_q[d] < MIN_YELLOW_C)) begin
                v_yellow = 1'b1;
            end
            if ((prev_q[d] == RED) && (lights_in[d] == GREEN) &&
                (allred_q < MIN_ALLRED_C)) begin
                v_allred = 1'b1;
            end
        end
        v_conflict = (nonred_cnt > 3'd1);

        if (v_encoding) begin
            viol_code = CODE_ENCODING;
        end else if (v_conflict) begin
            viol_code = CODE_CONFLICT;
        end else if (v_sequence) begin
            viol_code = CODE_SEQUENCE;
        end else if (v_green) begin
            viol_code = CODE_GREEN;
        end else if (v_yellow) begin
            viol_code = CODE_YELLOW;
        end else if (v_allred) begin
            viol_code = CODE_ALLRED;
        end else begin
            viol_code = CODE_NONE;
        end
    end

    // Next-state logic: history tracking runs in both states, then the FSM
    // decides forwarding, fault entry, flashing and clear acceptance.
    always_comb begin
        state_d      = state_q;
        prev_d       = lights_in;
        run_d        = run_q;
        allred_d     = allred_q;
        flash_cnt_d  = flash_cnt_q;
        flash_dark_d = flash_dark_q;
        out_d        = out_q;
        code_d       = code_q;
        vcount_d     = vcount_q;

        // Hold-time per direction restarts at 1 whenever the value changes.
        for (int d = 0; d < 4; d++) begin
            if (lights_in[d] != prev_q[d]) begin
                run_d[d] = 8'd1;
            end else if (run_q[d] != SAT_MAX) begin
                run_d[d] = run_q[d] + 8'd1;
            end
        end

        // Consecutive all-RED samples, cleared by any non-RED input.
        if (!all_red) begin
            allred_d = 8'd0;
        end else if (allred_q != SAT_MAX) begin
            allred_d = allred_q + 8'd1;
        end

        unique case (state_q)
            S_MONITOR: begin
                if (viol_code != CODE_NONE) begin
                    // The offending sample is never forwarded.
                    state_d      = S_FAULT;
                    code_d       = viol_code;
                    out_d        = {4{RED}};
                    flash_cnt_d  = 8'd0;
                    flash_dark_d = 1'b0;
                    if (vcount_q != SAT_MAX) begin
                        vcount_d = vcount_q + 8'd1;
                    end
                end else begin
                    out_d = lights_in;
                end
            end
            S_FAULT: begin
                if (clear_fault && all_red) begin
                    // Restart clearance timing so the next GREEN must wait
                    // out a full all-RED interval after the clear.
                    state_d      = S_MONITOR;
                    code_d       = CODE_NONE;
                    out_d        = {4{RED}};
                    allred_d     = 8'd0;
                    flash_cnt_d  = 8'd0;
                    flash_dark_d = 1'b0;
                end else begin
                    // The phase bit seen now drives this edge's output; the
                    // counter flips it after FLASH_HALF edges in a phase.
                    out_d = flash_dark_q ? {4{DARK}} : {4{RED}};
                    if (flash_cnt_q >= FLASH_LAST_C) begin
                        flash_cnt_d  = 8'd0;
                        flash_dark_d = ~flash_dark_q;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_MONITOR;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_MONITOR;
            prev_q       <= {4{RED}};
            run_q        <= '0;
            allred_q     <= MIN_ALLRED_C;
            flash_cnt_q  <= 8'd0;
            flash_dark_q <= 1'b0;
            out_q        <= {4{RED}};
            code_q       <= CODE_NONE;
            vcount_q     <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            allred_q     <= allred_d;
            flash_cnt_q  <= flash_cnt_d;
            flash_dark_q <= flash_dark_d;
            out_q        <= out_d;
            code_q       <= code_d;
            vcount_q     <= vcount_d;
        end
    end

    assign North_out       = out_q[0];
    assign East_out        = out_q[1];
    assign South_out       = out_q[2];
    assign West_out        = out_q[3];
    assign fault           = (state_q == S_FAULT);
    assign fault_code      = code_q;
    assign violation_count = vcount_q;

endmodule

// File: tb/tb_traffic_light_safety_monitor.sv
// Bench for traffic_light_safety_monitor. Two instances share the stimulus:
// instance 0 uses default parameters, instance 1 uses MIN_ALLRED=2. A
// rule-level model predicts both every cycle; directed literal checks pin
// the model against hand-computed values.
module tb_traffic_light_safety_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam int FLASH  = 4;
    localparam int MIN_G  = 4;
    localparam int MIN_Y  = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] north, east, south, west;
    logic       clr;
    logic       chk_en;

    logic [2:0] dut_out   [2][4];
    logic       dut_fault [2];
    logic [2:0] dut_code  [2];
    logic [7:0] dut_cnt   [2];

    int checks;
    int errors;

    // Model state per instance.
    logic [2:0] m_prev   [2][4];
    int         m_run    [2][4];
    int         m_allred [2];
    bit         m_fault  [2];
    int         m_code   [2];
    int         m_cnt    [2];
    int         m_j      [2];
    logic [2:0] m_out    [2][4];

    traffic_light_safety_monitor u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .North(north), .East(east), .South(south), .West(west),
        .clear_fault(clr),
        .North_out(dut_out[0][0]), .East_out(dut_out[0][1]),
        .South_out(dut_out[0][2]), .West_out(dut_out[0][3]),
        .fault(dut_fault[0]), .fault_code(dut_code[0]),
        .violation_count(dut_cnt[0])
    );

    traffic_light_safety_monitor #(.MIN_ALLRED(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .North(north), .East(east), .South(south), .West(west),
        .clear_fault(clr),
        .North_out(dut_out[1][0]), .East_out(dut_out[1][1]),
        .South_out(dut_out[1][2]), .West_out(dut_out[1][3]),
        .fault(dut_fault[1]), .fault_code(dut_code[1]),
        .violation_count(dut_cnt[1])
    );

    // Clock and reset defaults.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [2:0] x);
        return (x == R) || (x == Y) || (x == G);
    endfunction

    // Code raised by one direction's change of value, 0 if the change is fine.
    function automatic int trans_code(input logic [2:0] p, input logic [2:0] c,
                                      input int run, input int allred,
                                      input int min_ar);
        if (p == c) return 0;
        if ((p == G && c == R) || (p == R && c == Y) || (p == Y && c == G)) return 3;
        if (p == G && c == Y) return (run < MIN_G) ? 4 : 0;
        if (p == Y && c == R) return (run < MIN_Y) ? 5 : 0;
        if (p == R && c == G) return (allred < min_ar) ? 6 : 0;
        return 0;
    endfunction

    function automatic int lowest(input int best, input int c);
        if (c != 0 && (best == 0 || c < best)) return c;
        return best;
    endfunction

    // One rising edge of the model for instance i.
    task automatic model_step(input int i);
        logic [2:0] v[4];
        int  code;
        int  nonred;
        bit  allr;
        bit  cleared;
        int  min_ar;
        min_ar = (i == 0) ? 1 : 2;
        v[0] = north; v[1] = east; v[2] = south; v[3] = west;
        if (!rst_n) begin
            for (int d = 0; d < 4; d++) begin
                m_prev[i][d] = R; m_run[i][d] = 0; m_out[i][d] = R;
            end
            m_allred[i] = min_ar;
            m_fault[i]  = 0; m_code[i] = 0; m_cnt[i] = 0; m_j[i] = 0;
            return;
        end
        allr    = (v[0] == R) && (v[1] == R) && (v[2] == R) && (v[3] == R);
        cleared = 0;
        if (!m_fault[i]) begin
            code = 0; nonred = 0;
            for (int d = 0; d < 4; d++) begin
                if (!legal(v[d])) code = lowest(code, 1);
                if (v[d] != R) nonred++;
                code = lowest(code, trans_code(m_prev[i][d], v[d], m_run[i][d],
                                               m_allred[i], min_ar));
            end
            if (nonred > 1) code = lowest(code, 2);
            if (code != 0) begin
                m_fault[i] = 1; m_code[i] = code; m_j[i] = 0;
                if (m_cnt[i] < 255) m_cnt[i]++;
                for (int d = 0; d < 4; d++) m_out[i][d] = R;
            end else begin
                for (int d = 0; d < 4; d++) m_out[i][d] = v[d];
            end
        end else if (clr && allr) begin
            m_fault[i] = 0; m_code[i] = 0; cleared = 1;
            for (int d = 0; d < 4; d++) m_out[i][d] = R;
        end else begin
            m_j[i]++;
            for (int d = 0; d < 4; d++)
                m_out[i][d] = ((((m_j[i] - 1) / FLASH) % 2) != 0) ? 3'b000 : R;
        end
        for (int d = 0; d < 4; d++) begin
            if (v[d] != m_prev[i][d]) m_run[i][d] = 1;
            else if (m_run[i][d] < 255) m_run[i][d]++;
            m_prev[i][d] = v[d];
        end
        if (!allr) m_allred[i] = 0;
        else if (m_allred[i] < 255) m_allred[i]++;
        if (cleared) m_allred[i] = 0;
    endtask

    // Model advances on every rising edge, using the same sampled inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                for (int d = 0; d < 4; d++)
                    check($sformatf("dut%0d out[%0d]", i, d),
                          int'(dut_out[i][d]), int'(m_out[i][d]));
                check($sformatf("dut%0d fault", i), int'(dut_fault[i]), int'(m_fault[i]));
                check($sformatf("dut%0d code", i), int'(dut_code[i]), m_code[i]);
                check($sformatf("dut%0d count", i), int'(dut_cnt[i]), m_cnt[i]);
            end
        end
    end

    // Driver: apply inputs right after a falling edge, hold for n cycles.
    task automatic drive(input int n, input logic [2:0] nn, input logic [2:0] ee,
                         input logic [2:0] ss, input logic [2:0] ww,
                         input logic c);
        north = nn; east = ee; south = ss; west = ww; clr = c;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(2, R, R, R, R, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic int all_out(input int i);
        return {dut_out[i][0], dut_out[i][1], dut_out[i][2], dut_out[i][3]};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        do_reset();
        chk_en = 1'b1;

        // Reset state.
        check("reset outs", all_out(0), 12'h924);
        check("reset fault", int'(dut_fault[0]), 0);
        check("reset count", int'(dut_cnt[0]), 0);

        // Legal sequence: N G5 Y2, all-red 1, E G5 Y2.
        drive(1, G, R, R, R, 1'b0);
        check("legal N green fwd", int'(dut_out[0][0]), 1);
        drive(4, G, R, R, R, 1'b0);
        drive(2, Y, R, R, R, 1'b0);
        drive(1, R, R, R, R, 1'b0);
        drive(5, R, G, R, R, 1'b0);
        check("legal E green fwd", int'(dut_out[0][1]), 1);
        drive(2, R, Y, R, R, 1'b0);
        drive(2, R, R, R, R, 1'b0);
        check("legal fault", int'(dut_fault[0]), 0);
        check("legal count", int'(dut_cnt[0]), 0);

        // Conflict at edge k, then flash phases.
        drive(1, G, G, R, R, 1'b0);
        check("conflict outs", all_out(0), 12'h924);
        check("conflict fault", int'(dut_fault[0]), 1);
        check("conflict code", int'(dut_code[0]), 2);
        check("conflict count", int'(dut_cnt[0]), 1);
        drive(4, R, R, R, R, 1'b0);
        check("flash k+4 red", all_out(0), 12'h924);
        drive(1, R, R, R, R, 1'b0);
        check("flash k+5 dark", all_out(0), 0);
        drive(3, R, R, R, R, 1'b0);
        check("flash k+8 dark", all_out(0), 0);
        drive(1, R, R, R, R, 1'b0);
        check("flash k+9 red", all_out(0), 12'h924);

        // Clear handshake.
        drive(2, G, R, R, R, 1'b1);
        check("clear ignored", int'(dut_fault[0]), 1);
        drive(1, R, R, R, R, 1'b1);
        check("clear fault", int'(dut_fault[0]), 0);
        check("clear code", int'(dut_code[0]), 0);
        check("clear outs", all_out(0), 12'h924);
        check("clear count", int'(dut_cnt[0]), 1);
        drive(1, R, R, R, R, 1'b0);
        drive(1, G, G, R, R, 1'b0);
        check("second conflict count", int'(dut_cnt[0]), 2);

        // Priority: bad encoding beats conflict.
        do_reset();
        drive(1, G, G, R, 3'b011, 1'b0);
        check("priority code", int'(dut_code[0]), 1);
        check("priority count", int'(dut_cnt[0]), 1);

        // GREEN -> RED.
        do_reset();
        drive(5, G, R, R, R, 1'b0);
        drive(1, R, R, R, R, 1'b0);
        check("green to red code", int'(dut_code[0]), 3);

        // Short YELLOW.
        do_reset();
        drive(5, G, R, R, R, 1'b0);
        drive(1, Y, R, R, R, 1'b0);
        drive(1, R, R, R, R, 1'b0);
        check("short yellow code", int'(dut_code[0]), 5);

        // Short GREEN.
        do_reset();
        drive(3, G, R, R, R, 1'b0);
        drive(1, Y, R, R, R, 1'b0);
        check("short green code", int'(dut_code[0]), 4);

        // All-red clearance: instance 1 needs two all-red cycles.
        do_reset();
        drive(5, R, G, R, R, 1'b0);
        drive(2, R, Y, R, R, 1'b0);
        drive(1, R, R, R, R, 1'b0);
        drive(1, G, R, R, R, 1'b0);
        check("allred2 code", int'(dut_code[1]), 6);
        check("allred1 no fault", int'(dut_fault[0]), 0);

        // Reset during the dark flash phase.
        do_reset();
        drive(1, G, G, R, R, 1'b0);
        drive(5, R, R, R, R, 1'b0);
        check("midflash dark", all_out(0), 0);
        rst_n = 1'b0;
        drive(1, R, R, R, R, 1'b0);
        check("midflash rst outs", all_out(0), 12'h924);
        check("midflash rst fault", int'(dut_fault[0]), 0);
        check("midflash rst count", int'(dut_cnt[0]), 0);
        rst_n = 1'b1;
        drive(1, G, R, R, R, 1'b0);
        check("post rst green fault", int'(dut_fault[0]), 0);
        check("post rst green fwd", int'(dut_out[0][0]), 1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_safety_monitor.md
# traffic_light_safety_monitor

Conflict monitor sitting directly downstream of `traffic_light_controller`. It samples the four one-hot light outputs each cycle and forwards them, registered, to the lamp drivers. It checks encoding, mutual exclusion, phase sequence and minimum phase durations. On any violation it latches a fault code and overrides all four outputs with flashing red until an operator clear.

## Interface
- MIN_GREEN, 4: minimum consecutive GREEN cycles before GREEN->YELLOW (1..255)
- MIN_YELLOW, 2: minimum consecutive YELLOW cycles before YELLOW->RED (1..255)
- MIN_ALLRED, 1: minimum consecutive all-RED cycles before any RED->GREEN (0..255)
- FLASH_HALF, 4: half-period of fault flash, cycles (1..255)
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk
- North, East, South, West  input  3 each  controller lights; RED=3'b100, YELLOW=3'b010, GREEN=3'b001
- clear_fault  input  1  operator fault clear, level-sampled
- North_out, East_out, South_out, West_out  output  3 each  lamp drive (same encoding; 3'b000 = dark)
- fault  output  1  monitor in fault state
- fault_code  output  3  first violation code, held until clear; 0 = none
- violation_count  output  8  faults entered since reset, saturates at 255

## Operation
- States: MONITOR, FAULT_FLASH. Reset -> MONITOR.
- Reset values: all *_out = RED, fault=0, fault_code=0, violation_count=0. prev[d]=RED and run[d]=0 for each direction d. allred_cnt=MIN_ALLRED, meaning clearance is treated as satisfied. flash_cnt=0.
- Tracking, every cycle in both states:
  - run[d]: cycles the current value has been held; 1 on a change, otherwise +1, saturating at 255.
  - prev[d] <= input.
  - allred_cnt: consecutive all-RED samples, saturating at 255; 0 when any input is non-RED.
- Checks, in MONITOR only, evaluated on the sampled inputs against prev/run/allred_cnt:
  - 1: any input not exactly one of RED/YELLOW/GREEN.
  - 2: more than one direction non-RED.
  - 3: illegal transition GREEN->RED, RED->YELLOW or YELLOW->GREEN.
  - 4: GREEN->YELLOW with run[d] < MIN_GREEN.
  - 5: YELLOW->RED with run[d] < MIN_YELLOW.
  - 6: RED->GREEN with allred_cnt < MIN_ALLRED.
- Simultaneous violations: the lowest code wins. Only one fault is entered and the count increments by 1.
- MONITOR with no violation: *_out <= inputs.
- MONITOR with a violation: -> FAULT_FLASH. fault<=1, fault_code<=code, violation_count += 1 (saturating), *_out <= RED, flash_cnt <= 0.
- FAULT_FLASH:
  - No checks are performed.
  - Outputs are RED for FLASH_HALF cycles, then 3'b000 for FLASH_HALF cycles, repeating.
  - Exit requires clear_fault=1 in a cycle where all four inputs are RED. On that edge: -> MONITOR, fault<=0, fault_code<=0, *_out<=RED, allred_cnt<=0.
  - clear_fault is ignored if any input is non-RED, and ignored in MONITOR.
- rst_n low in any state restores all reset values at that edge, including mid-flash.

## Timing
- Pass-through latency is 1 cycle: the input sampled at edge k appears on *_out after edge k.
- Violation sampled at edge k: fault, fault_code and all-RED outputs are visible after edge k. The offending value is never forwarded.
- Flash phases:
  - Outputs are RED after edges k .. k+FLASH_HALF.
  - Outputs are 000 after edges k+FLASH_HALF+1 .. k+2*FLASH_HALF, and so on.
  - Sampled values must be exact; no glitch on phase change.
- Clear at edge c: fault=0 after c. The checks at edge c+1 compare against prev=RED with allred_cnt=0.
- Counters saturate; there is no wrap-around anywhere.

## Test plan
All scenarios use default parameters.
- Legal sequence after reset:
  - Stimulus: N GREEN 5 cycles, YELLOW 2, all RED 1, then E GREEN 5, YELLOW 2.
  - Response: *_out equals the inputs one cycle later, fault=0, violation_count=0.
- Conflict:
  - Stimulus: N=E=GREEN sampled at edge k.
  - Response: after k, all *_out=100, fault=1, fault_code=2, count=1. After edge k+5 outputs are 000; after k+9 they are 100.
- Priority:
  - Stimulus: West=3'b011 together with N=E=GREEN in the same cycle.
  - Response: fault_code=1 and count increments by exactly 1.
- Sequence and duration faults, each run from a fresh reset:
  - GREEN->RED on N gives code 3.
  - YELLOW held 1 cycle then RED gives code 5.
  - GREEN 3 cycles then YELLOW gives code 4.
  - With MIN_ALLRED=2: E GREEN->YELLOW->RED followed by N GREEN after 1 all-RED cycle gives code 6.
- Clear handshake:
  - clear_fault=1 with North GREEN: stays in fault.
  - clear_fault=1 with all inputs RED: fault=0, fault_code=0, outputs 100, count unchanged.
  - Second conflict after the clear: count=2.
- Reset mid-flash:
  - Stimulus: rst_n=0 for one edge during the dark phase.
  - Response: outputs 100, fault=0, count=0. An immediate N GREEN then raises no fault.
